// File: rtl/spi_slave_rram_if.sv
// SPI pin bundle between an SPI master and the RRAM register slave.
//   sc        : chip select, active-high, driven by the master
//   mosi      : serial data master -> slave, MSB first
//   miso      : serial data slave -> master
//   miso_oe_n : active-low output enable for the miso pad
// sclk is carried as a plain clock port on the slave, not in this bundle.
interface spi_slave_rram_if;
  logic sc;
  logic mosi;
  logic miso;
  logic miso_oe_n;

  modport master (output sc, output mosi, input miso, input miso_oe_n);
  modport slave  (input sc, input mosi, output miso, output miso_oe_n);
endinterface

// File: rtl/spi_slave_rram.sv
// SPI register slave for an RRAM test macro.
// Frame (sc high): 1 R/W bit (1 = write), ADDR_W address bits, DATA_W data
// bits, all MSB first and sampled on rising sclk. Read data leaves on miso
// from the edge that completes the address. Writes commit on the last frame
// edge only, so a frame cut short by sc or rst never touches the registers.
// Ports:
//   sclk, rst              : SPI clock, asynchronous active-high reset
//   spi (slave modport)    : sc, mosi, miso, miso_oe_n
//   fsm_go                 : one-sclk-cycle pulse on a committed write to GO
//   fsm_bits, diag_bits, diag2_bits, read_data_bits : read-only status inputs
//   rangei                 : low byte of the RANGE register
module spi_slave_rram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 sclk,
  input  logic                 rst,
  spi_slave_rram_if.slave      spi,
  output logic                 fsm_go,
  input  logic [15:0]          fsm_bits,
  input  logic [31:0]          diag_bits,
  input  logic [31:0]          diag2_bits,
  input  logic [47:0]          read_data_bits,
  output logic [7:0]           rangei
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);

  // bit_cnt holds the number of edges already taken in this frame
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);     // before last addr edge
  localparam logic [CNT_W-1:0] COMMIT_AT = CNT_W'(FRAME - 1);  // before final edge
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME);      // saturated

  localparam logic [ADDR_W-1:0] A_RANGE   = ADDR_W'(5'h00);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(5'h01);
  localparam logic [ADDR_W-1:0] A_FSM     = ADDR_W'(5'h10);
  localparam logic [ADDR_W-1:0] A_DIAG    = ADDR_W'(5'h11);
  localparam logic [ADDR_W-1:0] A_DIAG2   = ADDR_W'(5'h12);
  localparam logic [ADDR_W-1:0] A_RDLO    = ADDR_W'(5'h13);
  localparam logic [ADDR_W-1:0] A_RDHI    = ADDR_W'(5'h14);
  localparam logic [ADDR_W-1:0] A_GO      = ADDR_W'(5'h1F);

  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W:0]   hdr_sr;      // {rw, addr} once the header is complete
  logic [DATA_W-2:0] data_sr;     // last data bit comes straight from mosi
  logic [DATA_W-1:0] out_sr;
  logic              rd_phase;
  logic              blocked;
  logic [7:0]        range_reg;
  logic [DATA_W-1:0] scratch_reg;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_value;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              commit;

  // Address and data as seen on the edge that completes them.
  assign rd_addr = {hdr_sr[ADDR_W-2:0], spi.mosi};
  assign wr_addr = hdr_sr[ADDR_W-1:0];
  assign wr_data = {data_sr, spi.mosi};
  assign commit  = spi.sc && !blocked && (bit_cnt == COMMIT_AT) && hdr_sr[ADDR_W];

  always_comb begin
    rd_value = '0;
    case (rd_addr)
      A_RANGE:   rd_value = DATA_W'(range_reg);
      A_SCRATCH: rd_value = scratch_reg;
      A_FSM:     rd_value = DATA_W'(fsm_bits);
      A_DIAG:    rd_value = DATA_W'(diag_bits);
      A_DIAG2:   rd_value = DATA_W'(diag2_bits);
      A_RDLO:    rd_value = DATA_W'(read_data_bits[31:0]);
      A_RDHI:    rd_value = DATA_W'(read_data_bits[47:32]);
      default:   rd_value = '0;
    endcase
  end

  // A reset landing inside a frame must not let the remaining edges of that
  // frame look like a fresh one. blocked is raised by rst only while sc is
  // high and dropped as soon as sc goes low, so a reset taken with sc idle
  // never holds off the next frame.
  always_ff @(posedge sclk or posedge rst or negedge spi.sc) begin
    if (!spi.sc) begin
      blocked <= 1'b0;
    end else if (rst) begin
      blocked <= 1'b1;
    end
  end

  // Frame state: cleared whenever sc is low or rst is high.
  always_ff @(posedge sclk or posedge rst or negedge spi.sc) begin
    if (rst || !spi.sc) begin
      bit_cnt  <= '0;
      hdr_sr   <= '0;
      data_sr  <= '0;
      out_sr   <= '0;
      rd_phase <= 1'b0;
    end else if (!blocked && bit_cnt != FRAME_END) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (bit_cnt <= HDR_LAST) begin
        hdr_sr <= {hdr_sr[ADDR_W-1:0], spi.mosi};
      end else begin
        data_sr <= {data_sr[DATA_W-3:0], spi.mosi};
      end
      // rw was shifted in first and sits at hdr_sr[ADDR_W-1] one edge early
      if (bit_cnt == HDR_LAST && !hdr_sr[ADDR_W-1]) begin
        out_sr   <= rd_value;
        rd_phase <= 1'b1;
      end else begin
        out_sr <= {out_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  // out_sr stays zero outside a read data phase, so miso idles low.
  assign spi.miso      = out_sr[DATA_W-1];
  assign spi.miso_oe_n = ~rd_phase;

  // Configuration registers survive sc; only rst clears them.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      range_reg   <= '0;
      scratch_reg <= '0;
      fsm_go      <= 1'b0;
    end else begin
      fsm_go <= 1'b0;
      if (commit) begin
        case (wr_addr)
          A_RANGE:   range_reg   <= wr_data[7:0];
          A_SCRATCH: scratch_reg <= wr_data;
          A_GO:      fsm_go      <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  assign rangei = range_reg;

endmodule

// File: tb/tb_spi_slave_rram.sv
// Directed bench for spi_slave_rram: frames are driven on falling sclk and
// the DUT is sampled 1 ns after each rising edge.
module tb_spi_slave_rram;

  logic        sclk;
  logic        rst;
  logic        fsm_go;
  logic [15:0] fsm_bits;
  logic [31:0] diag_bits;
  logic [31:0] diag2_bits;
  logic [47:0] read_data_bits;
  logic [7:0]  rangei;

  int errors = 0;
  int checks = 0;

  spi_slave_rram_if spi_bus ();

  spi_slave_rram #(.ADDR_W(5), .DATA_W(32)) dut (
    .sclk           (sclk),
    .rst            (rst),
    .spi            (spi_bus),
    .fsm_go         (fsm_go),
    .fsm_bits       (fsm_bits),
    .diag_bits      (diag_bits),
    .diag2_bits     (diag2_bits),
    .read_data_bits (read_data_bits),
    .rangei         (rangei)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // One frame of nbits edges; edges past 38 send mosi=1.
  // rdata collects miso after edges 6..37, oe_err counts enable/idle
  // violations, go_cnt counts edges after which fsm_go was high.
  task automatic spi_frame(input logic rw, input logic [4:0] addr,
                           input logic [31:0] wdata, input int nbits,
                           output logic [31:0] rdata, output int oe_err,
                           output int go_cnt, output logic go_last,
                           output logic [7:0] range37);
    logic [37:0] fb;
    logic        exp_oe_n;
    fb = {rw, addr, wdata};
    rdata = '0; oe_err = 0; go_cnt = 0; go_last = 1'b0; range37 = rangei;
    @(negedge sclk);
    spi_bus.sc = 1'b1;
    #1;
    if (spi_bus.miso_oe_n !== 1'b1 || spi_bus.miso !== 1'b0) oe_err++;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.mosi = (i < 38) ? fb[37-i] : 1'b1;
      @(posedge sclk);
      #1;
      if (i + 1 >= 6 && i + 1 <= 37) rdata[37-(i+1)] = spi_bus.miso;
      exp_oe_n = !(rw == 1'b0 && i + 1 >= 6);
      if (spi_bus.miso_oe_n !== exp_oe_n) oe_err++;
      if (exp_oe_n && spi_bus.miso !== 1'b0) oe_err++;
      if (fsm_go) go_cnt++;
      go_last = fsm_go;
      if (i + 1 == 37) range37 = rangei;
    end
    @(negedge sclk);
    spi_bus.sc = 1'b0;
    spi_bus.mosi = 1'b0;
    #1;
    if (spi_bus.miso_oe_n !== 1'b1 || spi_bus.miso !== 1'b0) oe_err++;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] rd; int oe; int gc; logic gl; logic [7:0] r37;
    spi_frame(1'b1, addr, wdata, 38, rd, oe, gc, gl, r37);
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] rdata,
                         output int oe_err);
    int gc; logic gl; logic [7:0] r37;
    spi_frame(1'b0, addr, 32'h0, 38, rdata, oe_err, gc, gl, r37);
  endtask

  task automatic test_reset;
    logic [31:0] rd; int oe;
    checks++;
    if (rangei !== 8'h00 || fsm_go !== 1'b0 || spi_bus.miso !== 1'b0 || spi_bus.miso_oe_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: rangei=%h fsm_go=%b miso=%b oe_n=%b required 00 0 0 1",
               rangei, fsm_go, spi_bus.miso, spi_bus.miso_oe_n);
    end
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'h0 || oe !== 0) begin
      errors++; $display("FAIL reset_scratch: got %h oe_err=%0d required 00000000 oe_err=0", rd, oe);
    end
    $display("test_reset: scratch=%h", rd);
  endtask

  task automatic test_range;
    logic [31:0] rd; int oe; int gc; logic gl; logic [7:0] r37;
    spi_frame(1'b1, 5'h00, 32'h000000A5, 38, rd, oe, gc, gl, r37);
    checks++;
    if (r37 !== 8'h00 || rangei !== 8'hA5 || oe !== 0) begin
      errors++;
      $display("FAIL range_commit: before_last=%h after=%h oe_err=%0d required 00 a5 0", r37, rangei, oe);
    end
    do_read(5'h00, rd, oe);
    checks++;
    if (rd !== 32'h000000A5 || oe !== 0) begin
      errors++; $display("FAIL range_read: got %h oe_err=%0d required 000000a5 0", rd, oe);
    end
    do_write(5'h00, 32'h12345678);
    do_read(5'h00, rd, oe);
    checks++;
    if (rd !== 32'h00000078 || rangei !== 8'h78) begin
      errors++; $display("FAIL range_upper: got %h rangei=%h required 00000078 78", rd, rangei);
    end
    $display("test_range: rangei=%h read=%h", rangei, rd);
  endtask

  task automatic test_scratch_ro;
    logic [31:0] rd; int oe;
    do_write(5'h01, 32'hDEADBEEF);
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'hDEADBEEF || oe !== 0) begin
      errors++; $display("FAIL scratch_rw: got %h oe_err=%0d required deadbeef 0", rd, oe);
    end
    do_write(5'h10, 32'hFFFFFFFF);
    do_read(5'h10, rd, oe);
    checks++;
    if (rd !== 32'h00001234) begin
      errors++; $display("FAIL ro_write_ignored: got %h required 00001234", rd);
    end
    do_write(5'h05, 32'h0000FFFF);
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'hDEADBEEF || rangei !== 8'h78) begin
      errors++; $display("FAIL unmapped_write: scratch=%h rangei=%h required deadbeef 78", rd, rangei);
    end
    $display("test_scratch_ro: scratch=%h", rd);
  endtask

  task automatic test_status_regs;
    logic [4:0]  addrs [6] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h05};
    logic [31:0] exps  [6] = '{32'h00001234, 32'hCAFEF00D, 32'h0BADF00D,
                              32'h01234567, 32'h0000ABCD, 32'h00000000};
    logic [31:0] rd; int oe;
    for (int k = 0; k < 6; k++) begin
      do_read(addrs[k], rd, oe);
      checks++;
      if (rd !== exps[k] || oe !== 0) begin
        errors++;
        $display("FAIL status_read addr=%h: got %h oe_err=%0d required %h 0", addrs[k], rd, oe, exps[k]);
      end
      $display("test_status_regs: addr=%h read=%h", addrs[k], rd);
    end
  endtask

  task automatic test_go;
    logic [31:0] rd; int oe; int gc; logic gl; logic [7:0] r37;
    checks++;
    if (fsm_go !== 1'b0) begin
      errors++; $display("FAIL go_idle: got %b required 0", fsm_go);
    end
    spi_frame(1'b1, 5'h1F, 32'hFFFFFFFF, 38, rd, oe, gc, gl, r37);
    checks++;
    if (gc !== 1 || gl !== 1'b1) begin
      errors++; $display("FAIL go_pulse: high_edges=%0d after_last=%b required 1 1", gc, gl);
    end
    @(posedge sclk); #1;
    checks++;
    if (fsm_go !== 1'b0 || rangei !== 8'h78) begin
      errors++; $display("FAIL go_clear: fsm_go=%b rangei=%h required 0 78", fsm_go, rangei);
    end
    do_read(5'h1F, rd, oe);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL go_read: got %h required 00000000", rd);
    end
    $display("test_go: pulse_edges=%0d read=%h", gc, rd);
  endtask

  task automatic test_abort;
    logic [31:0] rd; int oe; int gc; logic gl; logic [7:0] r37;
    spi_frame(1'b1, 5'h01, 32'h11111111, 20, rd, oe, gc, gl, r37);
    spi_frame(1'b1, 5'h01, 32'h22222222, 37, rd, oe, gc, gl, r37);
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL abort_write: scratch=%h required deadbeef", rd);
    end
    // read cut short: sc falling must release miso at once (oe_err checks it)
    spi_frame(1'b0, 5'h01, 32'h0, 15, rd, oe, gc, gl, r37);
    checks++;
    if (oe !== 0 || rd[31:22] !== 10'b1101111010) begin
      errors++; $display("FAIL abort_read: oe_err=%0d top=%b required 0 1101111010", oe, rd[31:22]);
    end
    $display("test_abort: scratch=%h", 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int oe; int gc; logic gl; logic [7:0] r37;
    // extra edges past 38 must not shift or re-commit
    spi_frame(1'b1, 5'h01, 32'hA5A5A5A5, 45, rd, oe, gc, gl, r37);
    spi_frame(1'b0, 5'h01, 32'h0, 45, rd, oe, gc, gl, r37);
    checks++;
    if (rd !== 32'hA5A5A5A5 || oe !== 0) begin
      errors++; $display("FAIL saturate: got %h oe_err=%0d required a5a5a5a5 0", rd, oe);
    end
    do_write(5'h01, 32'h0F0F0F0F);
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'h0F0F0F0F) begin
      errors++; $display("FAIL back_to_back: got %h required 0f0f0f0f", rd);
    end
    $display("test_back_to_back: scratch=%h", rd);
  endtask

  task automatic test_rst_mid;
    logic [37:0] fb;
    logic [31:0] rd; int oe;
    fb = {1'b0, 5'h01, 32'h0};
    @(negedge sclk);
    spi_bus.sc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      spi_bus.mosi = fb[37-i];
      @(posedge sclk); #1;
    end
    checks++;
    if (spi_bus.miso_oe_n !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pre: oe_n=%b required 0", spi_bus.miso_oe_n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rangei !== 8'h00 || fsm_go !== 1'b0 || spi_bus.miso !== 1'b0 || spi_bus.miso_oe_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: rangei=%h fsm_go=%b miso=%b oe_n=%b required 00 0 0 1",
               rangei, fsm_go, spi_bus.miso, spi_bus.miso_oe_n);
    end
    @(negedge sclk);
    rst = 1'b0;
    // remaining edges of the interrupted frame must be ignored
    for (int i = 0; i < 8; i++) begin
      spi_bus.mosi = 1'b0;
      @(posedge sclk); #1;
    end
    checks++;
    if (spi_bus.miso_oe_n !== 1'b1 || spi_bus.miso !== 1'b0) begin
      errors++; $display("FAIL rst_mid_blocked: oe_n=%b miso=%b required 1 0", spi_bus.miso_oe_n, spi_bus.miso);
    end
    @(negedge sclk);
    spi_bus.sc = 1'b0;
    do_read(5'h01, rd, oe);
    checks++;
    if (rd !== 32'h0 || oe !== 0) begin
      errors++; $display("FAIL rst_mid_scratch: got %h oe_err=%0d required 00000000 0", rd, oe);
    end
    $display("test_rst_mid: scratch=%h rangei=%h", rd, rangei);
  endtask

  initial begin
    rst = 1'b0;
    spi_bus.sc = 1'b0;
    spi_bus.mosi = 1'b0;
    fsm_bits = 16'h1234;
    diag_bits = 32'hCAFEF00D;
    diag2_bits = 32'h0BADF00D;
    read_data_bits = 48'hABCD_01234567;
    #2 rst = 1'b1;
    #20 rst = 1'b0;
    #3;
    test_reset();
    test_range();
    test_scratch_ro();
    test_status_regs();
    test_go();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
